// File: rtl/seq_accum_pkg.sv
// seq_accum_pkg: shared state encoding for the sequential accumulate engine.
// The state register is one-hot; the index constants name each hot bit.
package seq_accum_pkg;

  // Bit position of each state inside the one-hot state register
  localparam int IDLE    = 0;
  localparam int ACC     = 1;
  localparam int DONE    = 2;
  localparam int STATE_N = 3;

  // One-hot state encoding; each value sets exactly the bit named above
  typedef enum logic [STATE_N-1:0] {
    ST_IDLE = 3'b001,
    ST_ACC  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

endpackage : seq_accum_pkg

// File: rtl/seq_accum_add.sv
// seq_accum_add: the single a+b adder of the engine.
// Build option SEQ_ACCUM_ENGINE_SAT_EN: when defined the sum clamps at the
// all-ones value instead of wrapping modulo 2^DATA_W.
module seq_accum_add #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

`ifdef SEQ_ACCUM_ENGINE_SAT_EN
  logic [DATA_W:0] full_s;

  // Widened add so the carry-out is visible for clamping
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b};
  end

  // Clamp to all-ones whenever the unsigned sum overflowed
  always_comb begin
    if (full_s[DATA_W]) begin
      sum = '1;
    end else begin
      sum = full_s[DATA_W-1:0];
    end
  end
`else
  // Plain modulo-2^DATA_W addition; the carry-out is simply dropped
  always_comb begin
    sum = a + b;
  end
`endif

endmodule : seq_accum_add

// File: rtl/seq_accum_engine.sv
// seq_accum_engine: loads a/b from init values on start, then adds b into a
// for 'iter' cycles, mirroring each sum into c, and pulses done at the end.
// Build option SEQ_ACCUM_ENGINE_SAT_EN selects saturating instead of
// wrapping addition (handled inside seq_accum_add).
module seq_accum_engine
  import seq_accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] init_a,
  input  logic [DATA_W-1:0] init_b,
  input  logic [ITER_W-1:0] iter,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic              busy,
  output logic              done
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   c_r;
  logic [ITER_W-1:0]   cnt_r;
  logic [DATA_W-1:0]   a_nxt_s;
  logic [DATA_W-1:0]   b_nxt_s;
  logic [DATA_W-1:0]   c_nxt_s;
  logic [ITER_W-1:0]   cnt_nxt_s;
  logic [DATA_W-1:0]   sum_s;

  // One shared adder feeds both a and c so they can never disagree
  seq_accum_add #(
    .DATA_W (DATA_W)
  ) u_add (
    .a   (a_r),
    .b   (b_r),
    .sum (sum_s)
  );

  // Next-state and next-data decode; everything holds unless a state acts
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    c_nxt_s     = c_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        // start wins over abort here since abort only acts in ACC
        if (start) begin
          a_nxt_s   = init_a;
          b_nxt_s   = init_b;
          c_nxt_s   = '0;
          cnt_nxt_s = iter;
          if (iter != '0) begin
            state_nxt_s = ST_ACC;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        // Abort leaves data frozen at the last completed step
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          a_nxt_s   = sum_s;
          c_nxt_s   = sum_s;
          cnt_nxt_s = cnt_r - ITER_W'(1);
          if (cnt_r == ITER_W'(1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        // Any corrupted one-hot pattern recovers to IDLE
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      c_r     <= c_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Status comes straight off state bits: no input-to-output path
  assign busy = ~state_r[IDLE];
  assign done = state_r[DONE];
  assign a    = a_r;
  assign b    = b_r;
  assign c    = c_r;

endmodule : seq_accum_engine

// File: doc/seq_accum_engine.md
SEQ_ACCUM_ENGINE -- requirements
Module: seq_accum_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the a, b and c data registers and of init_a and init_b.
REQ-002 SHALL have parameter ITER_W, default 4: width of the iter input and of the internal step counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: request a run; honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel an active run.
REQ-007 SHALL have port init_a, input, DATA_W bits: initial value of a.
REQ-008 SHALL have port init_b, input, DATA_W bits: initial value of b (the increment).
REQ-009 SHALL have port iter, input, ITER_W bits: number of accumulate steps, 0..2^ITER_W-1.
REQ-010 SHALL have ports a, b and c, output, DATA_W bits each: the registered data values.
REQ-011 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL implement a one-hot state register with states IDLE, ACC and DONE.
REQ-014 On a start edge in IDLE: a<=init_a, b<=init_b, c<=0, cnt<=iter, and next state is ACC if iter!=0, else DONE.
REQ-015 On each edge in ACC: a<=a+b, c<=a+b, b held, cnt<=cnt-1; next state is DONE when cnt==1, else ACC.
REQ-016 Latency SHALL be as follows: values after the start edge are visible the next cycle; each accumulate step takes exactly 1 cycle; done is asserted for the single cycle in which state==DONE, i.e. iter+1 cycles after the start edge.
REQ-017 DONE SHALL return to IDLE on the next edge, with a, b and c held.
REQ-018 start in ACC or DONE SHALL be ignored, with no queuing.
REQ-019 abort in ACC SHALL move the state to IDLE on the next edge, hold a, b and c at their current values, and not assert done; abort in IDLE or DONE has no effect.
REQ-020 Simultaneous start and abort in IDLE SHALL be treated as start.
REQ-021 Without the saturation feature, addition SHALL wrap modulo 2^DATA_W.
REQ-022 busy and done SHALL be driven from the state register only, with no combinational path from inputs.
REQ-023 init_a, init_b and iter SHALL be sampled only on the start edge; later changes have no effect on a run.

Reset
REQ-024 rst=1 at a clock edge SHALL force: state=IDLE, a=b=c=0, cnt=0, busy=0, done=0.
REQ-025 rst SHALL take priority over start and abort, including mid-run, where the run is discarded without a done pulse.
REQ-026 The first start SHALL be honoured on the first edge with rst=0.

Configuration
REQ-027 Macro SEQ_ACCUM_ENGINE_SAT_EN defined: a+b SHALL saturate at 2^DATA_W-1 (unsigned) for both a and c.
REQ-028 Macro SEQ_ACCUM_ENGINE_SAT_EN undefined: a+b SHALL wrap (REQ-021); no other behaviour differs.

Structure
REQ-029 Package seq_accum_pkg SHALL hold: the state-index constants (IDLE=0, ACC=1, DONE=2), the state-count constant, and the one-hot state typedef.
REQ-030 Sub-module seq_accum_add, parametrised by DATA_W, SHALL contain the adder and the wrap/saturate selection under SEQ_ACCUM_ENGINE_SAT_EN; it is instantiated once and its result feeds both a and c.

Verification
REQ-031 Nominal run: rst 1 cycle, then start with init_a=36, init_b=12, iter=1 -> next cycle a=36, b=12, c=0, busy=1; following cycle a=48, b=12, c=48, done=1; then busy=0.
REQ-032 Multi-step run: init_a=1, init_b=3, iter=5 -> a=c=16 at the done cycle; done high exactly 1 cycle, 6 cycles after the start edge.
REQ-033 Overflow, DATA_W=8: init_a=250, init_b=10, iter=1 -> a=c=4 without the macro; a=c=255 with SEQ_ACCUM_ENGINE_SAT_EN.
REQ-034 Zero iterations: iter=0, init_a=7 -> DONE the cycle after start, a=7, c=0, done=1.
REQ-035 Protocol misuse: start held high during a run with iter=3 -> second start ignored, exactly one done pulse; abort after 1 step -> a=init_a+init_b, no done, IDLE next cycle.
REQ-036 Reset mid-run: rst asserted in ACC -> next cycle all outputs 0, state IDLE, no done pulse ever.
